// File: rtl/stream_byte_encryptor.sv
// Byte-serial XOR stream cipher between a valid/ready byte source/sink and a pulse-driven keystream generator.
// Optional WAIT_HASH abort is compiled in when STREAM_ENC_TIMEOUT_EN is defined.
module stream_byte_encryptor #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [7:0]             data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    output logic                   request_hash_byte_pulse_out,
    input  logic [7:0]             hash_byte_in,
    input  logic                   hash_byte_pulse_in,
    output logic [7:0]             data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] byte_count,
    output logic                   timeout_error,
    output logic [1:0]             o_dbg_state
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQUEST   = 2'd1;
    localparam logic [1:0] ST_WAIT_HASH = 2'd2;
    localparam logic [1:0] ST_HOLD      = 2'd3;

    // Handshakes: a byte moves on either port at a rising edge where valid && ready;
    // data_out_valid/data_out never change while waiting for data_out_ready.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("stream_byte_encryptor: TIMEOUT_CYCLES must be in 2..65535");
    end

    logic [1:0]             r_state;
    logic [7:0]             r_pt;
    logic [7:0]             r_data_out;
    logic                   r_data_out_valid;
    logic [COUNT_WIDTH-1:0] r_byte_count;

    logic w_accept;
    logic w_hash_hit;
    logic w_out_done;
    logic w_timeout_hit;

    assign w_accept   = (r_state == ST_IDLE) && data_in_valid;
    assign w_hash_hit = (r_state == ST_WAIT_HASH) && hash_byte_pulse_in;
    assign w_out_done = (r_state == ST_HOLD) && data_out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state          <= ST_IDLE;
            r_pt             <= 8'h00;
            r_data_out       <= 8'h00;
            r_data_out_valid <= 1'b0;
            r_byte_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pt    <= data_in;
                        r_state <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    r_state <= ST_WAIT_HASH;
                end
                ST_WAIT_HASH: begin
                    // A strobe on the abort cycle still completes the byte.
                    if (w_hash_hit) begin
                        r_data_out       <= r_pt ^ hash_byte_in;
                        r_data_out_valid <= 1'b1;
                        r_state          <= ST_HOLD;
                    end else if (w_timeout_hit) begin
                        r_pt    <= 8'h00;
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (w_out_done) begin
                        r_data_out_valid <= 1'b0;
                        r_byte_count     <= r_byte_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                        r_state          <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef STREAM_ENC_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wait_cnt;
    logic        r_timeout_error;

    // Abort on the TIMEOUT_CYCLES-th strobe-less WAIT_HASH cycle.
    assign w_timeout_hit = (r_state == ST_WAIT_HASH) && !hash_byte_pulse_in && (r_wait_cnt == TO_LIMIT);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wait_cnt      <= 16'd0;
            r_timeout_error <= 1'b0;
        end else begin
            if (r_state == ST_REQUEST) begin
                r_wait_cnt <= 16'd0;
            end else if ((r_state == ST_WAIT_HASH) && !hash_byte_pulse_in && !w_timeout_hit) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_timeout_hit) begin
                r_timeout_error <= 1'b1;
            end
        end
    end

    assign timeout_error = r_timeout_error;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_error = 1'b0;
`endif

    assign data_in_ready               = (r_state == ST_IDLE);
    assign request_hash_byte_pulse_out = (r_state == ST_REQUEST);
    assign busy                        = (r_state != ST_IDLE);
    assign data_out                    = r_data_out;
    assign data_out_valid              = r_data_out_valid;
    assign byte_count                  = r_byte_count;
    assign o_dbg_state                 = r_state;

endmodule

// File: tb/tb_stream_byte_encryptor.sv
// Bench for stream_byte_encryptor: reference model is "output = plaintext XOR keystream, in order, one request per byte".
// Build with +define+STREAM_ENC_TIMEOUT_EN to also exercise the abort path (TIMEOUT_CYCLES = 4 here).
module tb_stream_byte_encryptor;
  localparam int CW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic [7:0]    data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic          request_hash_byte_pulse_out;
  logic [7:0]    hash_byte_in;
  logic          hash_byte_pulse_in;
  logic [7:0]    data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          busy;
  logic [CW-1:0] byte_count;
  logic          timeout_error;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ks_q[$];
  logic [CW-1:0] exp_count;
  int req_cnt = 0;
  bit gen_en = 1'b0;
  int gen_lat = 0;

  stream_byte_encryptor #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
    .clk(clk),
    .nrst(nrst),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .request_hash_byte_pulse_out(request_hash_byte_pulse_out),
    .hash_byte_in(hash_byte_in),
    .hash_byte_pulse_in(hash_byte_pulse_in),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .busy(busy),
    .byte_count(byte_count),
    .timeout_error(timeout_error),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (nrst && request_hash_byte_pulse_out) req_cnt++;
    if (nrst && data_out_valid && data_out_ready) got_q.push_back(data_out);
  end

  // Keystream generator: answers each request gen_lat+1 edges later with the next queued byte.
  initial begin
    logic [7:0] ks;
    forever begin
      @(negedge clk);
      if (gen_en && request_hash_byte_pulse_out && ks_q.size() > 0) begin
        ks = ks_q.pop_front();
        repeat (gen_lat + 1) @(posedge clk);
        #1;
        hash_byte_in = ks;
        hash_byte_pulse_in = 1'b1;
        @(posedge clk);
        #1;
        hash_byte_pulse_in = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] pt, output bit ok);
    ok = 1'b0;
    data_in = pt;
    data_in_valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (data_in_ready) ok = 1'b1;
      tick();
    end
    data_in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, output bit ok);
    for (int c = 0; c < 500 && got_q.size() < n; c++) tick();
    ok = (got_q.size() >= n);
  endtask

  task automatic wait_valid(output bit ok);
    for (int c = 0; c < 200 && !data_out_valid; c++) tick();
    ok = data_out_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nrst = 1'b0;
    data_in = 8'h00;
    data_in_valid = 1'b0;
    hash_byte_in = 8'h00;
    hash_byte_pulse_in = 1'b0;
    data_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (data_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", data_in_ready); else n_pass++;
    n_checks++;
    if (request_hash_byte_pulse_out !== 1'b0) $display("FAIL reset_req: got %b want 0", request_hash_byte_pulse_out); else n_pass++;
    n_checks++;
    if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out); else n_pass++;
    n_checks++;
    if (data_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", data_out_valid); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (byte_count !== '0) $display("FAIL reset_count: got %0d want 0", byte_count); else n_pass++;
    n_checks++;
    if (timeout_error !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_error); else n_pass++;
    nrst = 1'b1;
    exp_count = '0;
    tick();
    n_checks++;
    if ({busy, data_in_ready} !== 2'b01) $display("FAIL reset_release_idle: got busy/ready %b want 01", {busy, data_in_ready}); else n_pass++;
  endtask

  task automatic test_single_byte();
    bit ok;
    int r0;
    got_q.delete();
    exp_q.delete();
    gen_en = 1'b1;
    gen_lat = 2;
    data_out_ready = 1'b1;
    ks_q.push_back(8'h5A);
    exp_q.push_back(8'h41 ^ 8'h5A);
    r0 = req_cnt;
    push_byte(8'h41, ok);
    n_checks++;
    if (!ok) $display("FAIL single_accept: byte not accepted within budget"); else n_pass++;
    n_checks++;
    if ({request_hash_byte_pulse_out, busy, data_in_ready} !== 3'b110)
      $display("FAIL single_req_timing: got req/busy/in_ready %b want 110", {request_hash_byte_pulse_out, busy, data_in_ready});
    else n_pass++;
    wait_out(1, ok);
    exp_count++;
    n_checks++;
    if (!ok) $display("FAIL single_output: no output within budget"); else n_pass++;
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== 8'h1B) $display("FAIL single_data: got %h want 1b", (got_q.size() > 0) ? got_q[0] : 8'hxx); else n_pass++;
    n_checks++;
    if (req_cnt - r0 != 1) $display("FAIL single_req_count: got %0d want 1", req_cnt - r0); else n_pass++;
    n_checks++;
    if (byte_count !== exp_count) $display("FAIL single_count: got %0d want %0d", byte_count, exp_count); else n_pass++;
    n_checks++;
    if ({data_out_valid, busy} !== 2'b00) $display("FAIL single_back_idle: got valid/busy %b want 00", {data_out_valid, busy}); else n_pass++;
    data_out_ready = 1'b0;
    gen_en = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable;
    logic [7:0] pt, ks, held;
    got_q.delete();
    pt = 8'($urandom_range(0, 255));
    ks = 8'($urandom_range(0, 255));
    gen_en = 1'b1;
    gen_lat = 1;
    data_out_ready = 1'b0;
    ks_q.push_back(ks);
    push_byte(pt, ok);
    wait_valid(ok);
    n_checks++;
    if (!ok) $display("FAIL bp_valid: data_out_valid never rose"); else n_pass++;
    held = data_out;
    n_checks++;
    if (held !== (pt ^ ks)) $display("FAIL bp_data: got %h want %h", held, pt ^ ks); else n_pass++;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!data_out_valid || data_out !== held || data_in_ready || !busy) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL bp_stable: output/ready changed under backpressure, got stable=%b want 1", stable); else n_pass++;
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    exp_count++;
    n_checks++;
    if ({data_out_valid, busy} !== 2'b00) $display("FAIL bp_complete: got valid/busy %b want 00", {data_out_valid, busy}); else n_pass++;
    n_checks++;
    if (got_q.size() != 1) $display("FAIL bp_transfers: got %0d want 1", got_q.size()); else n_pass++;
    n_checks++;
    if (byte_count !== exp_count) $display("FAIL bp_count: got %0d want %0d", byte_count, exp_count); else n_pass++;
    gen_en = 1'b0;
  endtask

  task automatic test_spurious_strobe();
    int r0;
    got_q.delete();
    gen_en = 1'b0;
    data_out_ready = 1'b0;
    r0 = req_cnt;
    hash_byte_in = 8'hAA;
    hash_byte_pulse_in = 1'b1;
    tick();
    hash_byte_pulse_in = 1'b0;
    n_checks++;
    if ({busy, data_out_valid} !== 2'b00) $display("FAIL spur_idle: got busy/valid %b want 00", {busy, data_out_valid}); else n_pass++;
    data_in = 8'h0F;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    hash_byte_in = 8'h33;
    hash_byte_pulse_in = 1'b1;
    tick();
    hash_byte_pulse_in = 1'b0;
    tick();
    n_checks++;
    if ({busy, data_out_valid} !== 2'b10) $display("FAIL spur_request: got busy/valid %b want 10", {busy, data_out_valid}); else n_pass++;
    hash_byte_in = 8'hFF;
    hash_byte_pulse_in = 1'b1;
    tick();
    hash_byte_pulse_in = 1'b0;
    n_checks++;
    if (data_out_valid !== 1'b1 || data_out !== 8'hF0) $display("FAIL spur_data: got valid=%b data=%h want 1/f0", data_out_valid, data_out); else n_pass++;
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    exp_count++;
    n_checks++;
    if (byte_count !== exp_count) $display("FAIL spur_count: got %0d want %0d", byte_count, exp_count); else n_pass++;
    n_checks++;
    if (req_cnt - r0 != 1) $display("FAIL spur_req_count: got %0d want 1", req_cnt - r0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int r0, idx;
    got_q.delete();
    exp_q.delete();
    gen_en = 1'b1;
    gen_lat = 0;
    data_out_ready = 1'b1;
    r0 = req_cnt;
    for (int i = 0; i < 8; i++) begin
      ks_q.push_back(8'(8'h10 + i));
      exp_q.push_back(8'(i) ^ 8'(8'h10 + i));
    end
    idx = 0;
    data_in = 8'h00;
    data_in_valid = 1'b1;
    for (int c = 0; c < 400 && idx < 8; c++) begin
      if (data_in_ready) begin
        tick();
        idx++;
        data_in = 8'(idx);
      end else begin
        tick();
      end
    end
    data_in_valid = 1'b0;
    wait_out(8, ok);
    exp_count = exp_count + 16'd8;
    n_checks++;
    if (!ok) $display("FAIL b2b_outputs: got %0d transfers want 8", got_q.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL b2b_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (req_cnt - r0 != 8) $display("FAIL b2b_req_count: got %0d want 8", req_cnt - r0); else n_pass++;
    n_checks++;
    if (byte_count !== exp_count) $display("FAIL b2b_count: got %0d want %0d", byte_count, exp_count); else n_pass++;
    data_out_ready = 1'b0;
    gen_en = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    int r0;
    logic [7:0] pt, ks;
    got_q.delete();
    exp_q.delete();
    gen_en = 1'b1;
    r0 = req_cnt;
    for (int k = 0; k < 16; k++) begin
      pt = 8'($urandom_range(0, 255));
      ks = 8'($urandom_range(0, 255));
      ks_q.push_back(ks);
      exp_q.push_back(pt ^ ks);
      gen_lat = $urandom_range(0, 4);
      data_out_ready = 1'b0;
      push_byte(pt, ok);
      wait_valid(ok);
      repeat ($urandom_range(0, 3)) tick();
      data_out_ready = 1'b1;
      wait_out(k + 1, ok);
      data_out_ready = 1'b0;
      exp_count++;
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL rand_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (req_cnt - r0 != 16) $display("FAIL rand_req_count: got %0d want 16", req_cnt - r0); else n_pass++;
    n_checks++;
    if (byte_count !== exp_count) $display("FAIL rand_count: got %0d want %0d", byte_count, exp_count); else n_pass++;
    gen_en = 1'b0;
  endtask

`ifdef STREAM_ENC_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    logic [7:0] pt, ks;
    got_q.delete();
    gen_en = 1'b0;
    data_out_ready = 1'b0;
    // Strobe on the last allowed wait cycle wins over the abort.
    pt = 8'($urandom_range(0, 255));
    ks = 8'($urandom_range(0, 255));
    push_byte(pt, ok);
    repeat (4) tick();
    hash_byte_in = ks;
    hash_byte_pulse_in = 1'b1;
    tick();
    hash_byte_pulse_in = 1'b0;
    n_checks++;
    if (data_out_valid !== 1'b1 || data_out !== (pt ^ ks) || timeout_error !== 1'b0)
      $display("FAIL to_edge_strobe: got valid=%b data=%h err=%b want 1/%h/0", data_out_valid, data_out, timeout_error, pt ^ ks);
    else n_pass++;
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    exp_count++;
    got_q.delete();
    // No strobe: abort after four wait cycles.
    push_byte(8'h77, ok);
    repeat (4) tick();
    n_checks++;
    if ({busy, timeout_error} !== 2'b10) $display("FAIL to_still_waiting: got busy/err %b want 10", {busy, timeout_error}); else n_pass++;
    tick();
    n_checks++;
    if ({busy, timeout_error, data_out_valid} !== 3'b010) $display("FAIL to_abort: got busy/err/valid %b want 010", {busy, timeout_error, data_out_valid}); else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (got_q.size() != 0 || byte_count !== exp_count) $display("FAIL to_no_output: got %0d transfers count %0d want 0/%0d", got_q.size(), byte_count, exp_count); else n_pass++;
    gen_en = 1'b1;
    gen_lat = 1;
    data_out_ready = 1'b1;
    ks_q.push_back(8'h3C);
    push_byte(8'hC3, ok);
    wait_out(1, ok);
    exp_count++;
    n_checks++;
    if (!ok || got_q[0] !== 8'hFF) $display("FAIL to_next_byte: got %h want ff", ok ? got_q[0] : 8'hxx); else n_pass++;
    n_checks++;
    if (timeout_error !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout_error); else n_pass++;
    data_out_ready = 1'b0;
    gen_en = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    gen_en = 1'b0;
    data_out_ready = 1'b0;
    push_byte(8'h5C, ok);
    repeat (100) tick();
    n_checks++;
    if ({busy, data_out_valid, timeout_error} !== 3'b100) $display("FAIL nto_waiting: got busy/valid/err %b want 100", {busy, data_out_valid, timeout_error}); else n_pass++;
    hash_byte_in = 8'hC5;
    hash_byte_pulse_in = 1'b1;
    tick();
    hash_byte_pulse_in = 1'b0;
    n_checks++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h99) $display("FAIL nto_data: got valid=%b data=%h want 1/99", data_out_valid, data_out); else n_pass++;
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    exp_count++;
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    gen_en = 1'b0;
    data_out_ready = 1'b0;
    push_byte(8'h99, ok);
    repeat (2) tick();
    #2;
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({busy, data_in_ready, request_hash_byte_pulse_out, data_out_valid, timeout_error} !== 5'b01000)
      $display("FAIL rst_mid_ctrl: got busy/in_ready/req/valid/err %b want 01000",
               {busy, data_in_ready, request_hash_byte_pulse_out, data_out_valid, timeout_error});
    else n_pass++;
    n_checks++;
    if (data_out !== 8'h00 || byte_count !== '0) $display("FAIL rst_mid_data: got data=%h count=%0d want 00/0", data_out, byte_count); else n_pass++;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    exp_count = '0;
    tick();
    test_single_byte();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_byte();
    test_backpressure();
    test_spurious_strobe();
    test_back_to_back();
    test_random();
`ifdef STREAM_ENC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
